// File: rtl/lzd_share_ctrl.sv
// Two-requester sequencer/arbiter sharing one pipelined 48-bit leading-zero detector.
// Optional stall counters: define LZD_PERF_CNT_EN to add stall_cnt_0/stall_cnt_1.
module lzd_share_ctrl #(
  parameter int unsigned LZD_LAT    = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic [47:0] req_data_0,
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic [47:0] req_data_1,
  output logic [47:0] lzd_a,
  input  logic [5:0]  lzd_p,
  input  logic        lzd_v,
  output logic        rsp_valid_0,
  input  logic        rsp_ready_0,
  output logic [5:0]  rsp_lz_0,
  output logic        rsp_zero_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_1,
  output logic [5:0]  rsp_lz_1,
  output logic        rsp_zero_1
`ifdef LZD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_0,
  output logic [CNT_W-1:0] stall_cnt_1
`endif
);

  localparam int unsigned PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW      = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [5:0]  LZ_ZERO = 6'd48;

  typedef enum logic {
    RR_REQ0 = 1'b0,
    RR_REQ1 = 1'b1
  } rr_e;

  rr_e              rr_q, rr_d;
  logic [47:0]      lzd_a_q, lzd_a_d;
  logic [LZD_LAT:0] tag_v_q, tag_o_q;

  logic [1:0]       req_valid, rsp_ready, eligible, cand, gnt, rsp_valid;
  logic [1:0][6:0]  head;
  logic             ret_v, ret_o;
  logic [6:0]       ret_ent;

  assign req_valid = {req_valid_1, req_valid_0};
  assign rsp_ready = {rsp_ready_1, rsp_ready_0};

  // Eligibility comes from registered credit state only; rst gates grants while held.
  always_comb begin
    cand = req_valid & eligible & {2{~rst}};
    gnt  = cand;
    if (cand == 2'b11) begin
      gnt = (rr_q == RR_REQ0) ? 2'b01 : 2'b10;
    end
    rr_d = rr_q;
    if (gnt[0]) begin
      rr_d = RR_REQ1;
    end else if (gnt[1]) begin
      rr_d = RR_REQ0;
    end
    lzd_a_d = lzd_a_q;
    if (gnt[0]) begin
      lzd_a_d = req_data_0;
    end else if (gnt[1]) begin
      lzd_a_d = req_data_1;
    end
  end

  assign req_ready_0 = gnt[0];
  assign req_ready_1 = gnt[1];
  assign lzd_a       = lzd_a_q;

  // Last tag stage lines up with the detector output of the same operand.
  assign ret_v   = tag_v_q[LZD_LAT];
  assign ret_o   = tag_o_q[LZD_LAT];
  assign ret_ent = lzd_v ? {1'b0, lzd_p} : {1'b1, LZ_ZERO};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q    <= RR_REQ0;
      lzd_a_q <= '0;
      tag_v_q <= '0;
      tag_o_q <= '0;
    end else begin
      rr_q    <= rr_d;
      lzd_a_q <= lzd_a_d;
      tag_v_q <= {tag_v_q[LZD_LAT-1:0], |gnt};
      tag_o_q <= {tag_o_q[LZD_LAT-1:0], gnt[1]};
    end
  end

  for (genvar n = 0; n < 2; n++) begin : g_req
    logic [CW-1:0] fcnt_q, fcnt_d, infl_q, infl_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [6:0]    mem_q [FIFO_DEPTH];
    logic          wr, pop;

    assign wr           = ret_v & ((n == 0) ? ~ret_o : ret_o);
    assign rsp_valid[n] = (fcnt_q != '0);
    assign pop          = rsp_valid[n] & rsp_ready[n];
    assign eligible[n]  = ({1'b0, fcnt_q} + {1'b0, infl_q}) < DEPTH_C;
    assign head[n]      = rsp_valid[n] ? mem_q[rptr_q] : '0;

    // Simultaneous inc/dec cancel, so issue+return or write+pop leave counts unchanged.
    always_comb begin
      fcnt_d = fcnt_q + CW'(wr) - CW'(pop);
      infl_d = infl_q + CW'(gnt[n]) - CW'(wr);
      wptr_d = wptr_q + PW'(wr);
      rptr_d = rptr_q + PW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        fcnt_q <= '0;
        infl_q <= '0;
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        fcnt_q <= fcnt_d;
        infl_q <= infl_d;
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
      end
    end

    always_ff @(posedge clk) begin
      if (wr) begin
        mem_q[wptr_q] <= ret_ent;
      end
    end
  end

  assign rsp_valid_0 = rsp_valid[0];
  assign rsp_lz_0    = head[0][5:0];
  assign rsp_zero_0  = head[0][6];
  assign rsp_valid_1 = rsp_valid[1];
  assign rsp_lz_1    = head[1][5:0];
  assign rsp_zero_1  = head[1][6];

`ifdef LZD_PERF_CNT_EN
  logic [1:0][CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    for (int unsigned n = 0; n < 2; n++) begin
      if (req_valid[n] && !gnt[n] && (stall_q[n] != '1)) begin
        stall_d[n] = stall_q[n] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_0 = stall_q[0];
  assign stall_cnt_1 = stall_q[1];
`endif

endmodule
